// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: turns AXI-style INCR write/read burst commands into
// single-beat accesses on the two ports of a dual-port memory, and returns
// read beats through a 2-entry buffer that can never overflow.
//
// Handshake rule on every valid/ready pair: a transfer happens on the rising
// edge where valid and ready are both high; a source holds valid (and its
// payload) until that edge, and ready may depend combinationally on valid.
//
// Optional build macro: MEM_RAW_ORDER_EN. When defined, a read command is
// only accepted while the write side is idle and no write command is being
// accepted in the same cycle, so a read sees every write already started.
module mem_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  wr_cmd_len,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_resp_valid,
  input  logic                  wr_resp_ready,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_cmd_len,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_last,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_ISSUE}        rd_state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  // Command readies stay low during reset and the cycle reset is released in.
  logic rdy_en_q;

  // Ready-enable: rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  // ---------------------------------------------------------------- write side
  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_WIDTH-1:0]  wr_rem_q, wr_rem_d;
  logic                  wr_beat;

  // Write FSM state and burst counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_rem_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_rem_q   <= wr_rem_d;
    end
  end

  // Write FSM: accept a command, stream len+1 beats to memory, then respond.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_addr_d     = wr_addr_q;
    wr_rem_d      = wr_rem_q;
    wr_cmd_ready  = 1'b0;
    wr_data_ready = 1'b0;
    wr_resp_valid = 1'b0;
    wr_beat       = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        wr_cmd_ready = rdy_en_q;
        if (wr_cmd_valid && rdy_en_q) begin
          wr_addr_d  = wr_cmd_addr;
          wr_rem_d   = wr_cmd_len;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wr_data_ready = 1'b1;
        if (wr_data_valid) begin
          wr_beat   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_ONE;
          wr_rem_d  = wr_rem_q - LEN_ONE;
          if (wr_rem_q == '0) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        wr_resp_valid = 1'b1;
        if (wr_resp_ready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Memory write port is driven straight from the accepted beat.
  always_comb begin
    mem_write_en      = wr_beat;
    mem_write_address = wr_addr_q;
    mem_data_in       = wr_beat ? wr_data : '0;
  end

  // ----------------------------------------------------------------- read side
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]  rd_rem_q, rd_rem_d;
  logic                  rd_issue;
  logic                  rd_credit;
  logic                  rd_pop;
  logic                  rd_cmd_gate;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH:0]   fifo_mem_q [2];
  logic                  fifo_wptr_q;
  logic                  fifo_rptr_q;
  logic [1:0]            fifo_count_q;
  logic [2:0]            rd_occupancy;

`ifdef MEM_RAW_ORDER_EN
  assign rd_cmd_gate = (wr_state_q == W_IDLE) && !(wr_cmd_valid && wr_cmd_ready);
`else
  assign rd_cmd_gate = 1'b1;
`endif

  // Beats held or in flight after this edge's pop; issue only if one slot is free.
  assign rd_pop       = rd_data_valid && rd_data_ready;
  assign rd_occupancy = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, rd_pop};
  assign rd_credit    = (rd_occupancy < 3'd2);

  // Read FSM state and burst counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_rem_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_rem_q   <= rd_rem_d;
    end
  end

  // Read FSM: accept a command, then issue one memory read per credit.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_addr_d    = rd_addr_q;
    rd_rem_d     = rd_rem_q;
    rd_cmd_ready = 1'b0;
    rd_issue     = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        rd_cmd_ready = rdy_en_q && rd_cmd_gate;
        if (rd_cmd_valid && rdy_en_q && rd_cmd_gate) begin
          rd_addr_d  = rd_cmd_addr;
          rd_rem_d   = rd_cmd_len;
          rd_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (rd_credit) begin
          rd_issue  = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          rd_rem_d  = rd_rem_q - LEN_ONE;
          if (rd_rem_q == '0) rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign mem_read_en      = rd_issue;
  assign mem_read_address = rd_addr_q;

  // In-flight marker: memory data is valid the cycle after an issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && (rd_rem_q == '0);
    end
  end

  // Two-entry return buffer of {data, last}; pushed from the in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
      fifo_wptr_q  <= 1'b0;
      fifo_rptr_q  <= 1'b0;
      fifo_count_q <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_mem_q[fifo_wptr_q] <= {mem_data_out, inflight_last_q};
        fifo_wptr_q             <= ~fifo_wptr_q;
      end
      if (rd_pop) fifo_rptr_q <= ~fifo_rptr_q;
      unique case ({inflight_q, rd_pop})
        2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
        2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  assign rd_data_valid           = (fifo_count_q != 2'd0);
  assign {rd_data, rd_data_last} = fifo_mem_q[fifo_rptr_q];

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: models the dual-port memory, keeps a reference
// image of memory contents and expected queues for memory writes and read
// beats, and drives directed plus randomized bursts.
module tb_mem_burst_ctrl;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 8;
  localparam int DEPTH = 1 << AW;

  // ------------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_cmd_valid = 1'b0, wr_cmd_ready;
  logic [AW-1:0] wr_cmd_addr = '0;
  logic [LW-1:0] wr_cmd_len = '0;
  logic          wr_data_valid = 1'b0, wr_data_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_resp_valid, wr_resp_ready = 1'b0;
  logic          rd_cmd_valid = 1'b0, rd_cmd_ready;
  logic [AW-1:0] rd_cmd_addr = '0;
  logic [LW-1:0] rd_cmd_len = '0;
  logic          rd_data_valid, rd_data_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_data_last;
  logic          mem_write_en, mem_read_en;
  logic [AW-1:0] mem_write_address, mem_read_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;

  mem_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .rd_data(rd_data), .rd_data_last(rd_data_last),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_write_address(mem_write_address), .mem_read_address(mem_read_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Dual-port memory model: registered read, read-before-write.
  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_address] <= mem_data_in;
    if (mem_read_en)  mem_data_out <= mem[mem_read_address];
  end

  // ------------------------------------------------------------- scoreboard
  logic [DW-1:0]    ref_mem [DEPTH] = '{default: '0};
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [DW:0]      exp_rd_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int outst = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({wr_cmd_ready, wr_data_ready, wr_resp_valid, rd_cmd_ready, rd_data_valid,
                rd_data, rd_data_last, mem_write_en, mem_read_en, mem_write_address,
                mem_read_address, mem_data_in});
  endfunction

  // Monitor: memory writes and read beats against expected queues, plus the
  // at-most-two-outstanding-beats rule.
  always @(negedge clk) begin
    logic [AW+DW-1:0] ew;
    logic [DW:0]      er;
    int nxt;
    if (!rst_n) begin
      outst = 0;
    end else begin
      if (mem_write_en) begin
        if (exp_wr_q.size() == 0) check("mem_write_unexpected", mem_write_en, 0);
        else begin
          ew = exp_wr_q.pop_front();
          check("mem_write_addr_data", {mem_write_address, mem_data_in}, ew);
        end
      end
      if (rd_data_valid && rd_data_ready) begin
        if (exp_rd_q.size() == 0) check("rd_beat_unexpected", rd_data_valid, 0);
        else begin
          er = exp_rd_q.pop_front();
          check("rd_beat_data_last", {rd_data, rd_data_last}, {er[DW-1:0], er[DW]});
        end
      end
      nxt = outst + int'(mem_read_en) - int'(rd_data_valid && rd_data_ready);
      if (mem_read_en) check("rd_outstanding_le2", (nxt <= 2), 1);
      outst = nxt;
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic apply_reset();
    wr_cmd_valid = 0; wr_data_valid = 0; wr_resp_ready = 0; wr_data = '0;
    rd_cmd_valid = 0; rd_data_ready = 0;
    rst_n = 0;
    #1;
    check("reset_outputs_zero", all_outputs(), 0);
    exp_rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_hold", all_outputs(), 0);
    rst_n = 1;
    @(negedge clk);
    check("ready_low_release_cycle", {wr_cmd_ready, rd_cmd_ready}, 2'b00);
    @(posedge clk); #1;
    check("ready_rise_after_release", {wr_cmd_ready, rd_cmd_ready}, 2'b11);
  endtask

  // pat >= 0 gives data pat+i, otherwise random; gaps inserts idle cycles.
  task automatic write_burst(input logic [AW-1:0] addr, input int len, input int pat, input bit gaps);
    int t, n;
    bit hs;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    wr_cmd_addr = addr; wr_cmd_len = LW'(len); wr_cmd_valid = 1;
    t = 0;
    do begin @(negedge clk); hs = wr_cmd_ready; @(posedge clk); #1; t++; end while (!hs && t < 100);
    check("wr_cmd_handshake", hs, 1);
    wr_cmd_valid = 0;
    for (int i = 0; i <= len; i++) begin
      d = (pat >= 0) ? DW'(pat + i) : DW'($urandom_range(0, 255));
      a = AW'((int'(addr) + i) % DEPTH);
      exp_wr_q.push_back({a, d});
      ref_mem[a] = d;
      if (gaps) begin
        wr_data_valid = 0;
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge clk); #1; end
      end
      wr_data = d; wr_data_valid = 1;
      t = 0;
      do begin @(negedge clk); hs = wr_data_ready; @(posedge clk); #1; t++; end while (!hs && t < 50);
      if (gaps) check("wr_beat_handshake", hs, 1);
      else      check("wr_beat_one_per_cycle", t, 1);
    end
    wr_data_valid = 0; wr_data = '0;
    @(negedge clk);
    check("wr_resp_after_last_beat", wr_resp_valid, 1);
    wr_resp_ready = 1;
    @(posedge clk); #1;
    wr_resp_ready = 0;
    @(negedge clk);
    check("wr_resp_dropped", wr_resp_valid, 0);
    @(posedge clk); #1;
  endtask

  // mode 0: ready held high (latency checked), 1: ready toggles, 2: random ready.
  task automatic read_burst(input logic [AW-1:0] addr, input int len, input int mode);
    int t;
    bit hs;
    for (int i = 0; i <= len; i++)
      exp_rd_q.push_back({(i == len), ref_mem[(int'(addr) + i) % DEPTH]});
    rd_data_ready = (mode == 0);
    rd_cmd_addr = addr; rd_cmd_len = LW'(len); rd_cmd_valid = 1;
    t = 0;
    do begin @(negedge clk); hs = rd_cmd_ready; @(posedge clk); #1; t++; end while (!hs && t < 100);
    check("rd_cmd_handshake", hs, 1);
    rd_cmd_valid = 0;
    if (mode == 0) begin
      for (int c = 1; c <= len + 3; c++) begin
        @(negedge clk);
        check("rd_valid_latency", rd_data_valid, (c >= 3));
        if (c == 1) check("rd_issue_in_cycle1", mem_read_en, 1);
        @(posedge clk); #1;
      end
    end
    t = 0;
    while (exp_rd_q.size() != 0 && t < 300) begin
      case (mode)
        0:       rd_data_ready = 1;
        1:       rd_data_ready = ~rd_data_ready;
        default: rd_data_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      t++;
    end
    check("rd_burst_drained", exp_rd_q.size(), 0);
    rd_data_ready = 0;
  endtask

  // ----------------------------------------------------------- stimulus
  initial begin
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd [2];
    int t;
    bit hs;

    apply_reset();

    // Directed: write A0..A3 at 0x010, read back with ready high.
    write_burst(10'h010, 3, 8'hA0, 1'b0);
    read_burst(10'h010, 3, 0);
    // Read 8 beats with ready toggling.
    read_burst(10'h010, 7, 1);
    // Address wrap at top of memory.
    write_burst(10'h3FE, 3, -1, 1'b0);
    read_burst(10'h3FE, 3, 2);

    // Reset in the middle of a stalled read burst, then a single-beat read.
    rd_data_ready = 0;
    rd_cmd_addr = 10'h010; rd_cmd_len = 8'd7; rd_cmd_valid = 1;
    t = 0;
    do begin @(negedge clk); hs = rd_cmd_ready; @(posedge clk); #1; t++; end while (!hs && t < 100);
    check("rd_cmd_handshake_pre_reset", hs, 1);
    rd_cmd_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    apply_reset();
    read_burst(10'h011, 0, 0);

    // Randomized bursts.
    for (int k = 0; k < 6; k++) begin
      wa = AW'($urandom_range(0, DEPTH - 1));
      write_burst(wa, $urandom_range(0, 7), -1, 1'b1);
      ra = AW'((int'(wa) + DEPTH - int'($urandom_range(0, 2))) % DEPTH);
      read_burst(ra, $urandom_range(0, 11), (k % 2 == 0) ? 2 : 1);
    end

    // Write and read commands presented in the same cycle.
    wa = 10'h100;
`ifdef MEM_RAW_ORDER_EN
    ra = 10'h100;
`else
    ra = 10'h200;
`endif
    for (int i = 0; i < 2; i++) begin
      wd[i] = DW'($urandom_range(0, 255));
      exp_wr_q.push_back({AW'(int'(wa) + i), wd[i]});
      ref_mem[int'(wa) + i] = wd[i];
    end
    for (int i = 0; i < 2; i++) exp_rd_q.push_back({(i == 1), ref_mem[int'(ra) + i]});
    wr_cmd_addr = wa; wr_cmd_len = 8'd1; wr_cmd_valid = 1;
    rd_cmd_addr = ra; rd_cmd_len = 8'd1; rd_cmd_valid = 1;
    rd_data_ready = 1;
    @(negedge clk);
    check("ovl_wr_cmd_ready", wr_cmd_ready, 1);
`ifdef MEM_RAW_ORDER_EN
    check("ovl_rd_cmd_ready", rd_cmd_ready, 0);
`else
    check("ovl_rd_cmd_ready", rd_cmd_ready, 1);
`endif
    @(posedge clk); #1;
    wr_cmd_valid = 0;
`ifndef MEM_RAW_ORDER_EN
    rd_cmd_valid = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      wr_data = wd[i]; wr_data_valid = 1;
      @(negedge clk);
      check("ovl_wr_data_ready", wr_data_ready, 1);
`ifdef MEM_RAW_ORDER_EN
      check("ovl_rd_blocked_data", rd_cmd_ready, 0);
`endif
      @(posedge clk); #1;
    end
    wr_data_valid = 0; wr_data = '0;
    @(negedge clk);
    check("ovl_wr_resp_valid", wr_resp_valid, 1);
`ifdef MEM_RAW_ORDER_EN
    check("ovl_rd_blocked_resp", rd_cmd_ready, 0);
`endif
    wr_resp_ready = 1;
    @(posedge clk); #1;
    wr_resp_ready = 0;
`ifdef MEM_RAW_ORDER_EN
    @(negedge clk);
    check("ovl_rd_cmd_ready_after_resp", rd_cmd_ready, 1);
    @(posedge clk); #1;
    rd_cmd_valid = 0;
`endif
    t = 0;
    while (exp_rd_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    check("ovl_rd_drained", exp_rd_q.size(), 0);
    rd_data_ready = 0;

    repeat (2) begin @(posedge clk); #1; end
    check("all_writes_seen", exp_wr_q.size(), 0);
    check("all_reads_seen", exp_rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst sequencer in front of the dual-port `memory` block in the AXI_MM_BURST datapath. It accepts AXI-style INCR burst commands on independent write and read command channels. It turns each burst into single-beat memory port accesses with address increment, and returns read beats through a backpressure-safe 2-entry buffer. Write and read bursts run concurrently because the memory has separate ports, unless the ordering option below is compiled in.

## Interface

Parameters:
- DATA_WIDTH, 8, beat width; matches memory DATA_WIDTH
- ADDR_WIDTH, 10, word address width; memory holds 2^ADDR_WIDTH words
- LEN_WIDTH, 8, burst length field; beats = len+1 (1..2^LEN_WIDTH)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_cmd_valid / wr_cmd_ready  in/out  1  write command handshake
- wr_cmd_addr  in  ADDR_WIDTH  first beat address
- wr_cmd_len  in  LEN_WIDTH  beats-1
- wr_data_valid / wr_data_ready  in/out  1  write data handshake
- wr_data  in  DATA_WIDTH  write beat
- wr_resp_valid / wr_resp_ready  out/in  1  burst-complete response handshake
- rd_cmd_valid / rd_cmd_ready  in/out  1  read command handshake
- rd_cmd_addr  in  ADDR_WIDTH  first beat address
- rd_cmd_len  in  LEN_WIDTH  beats-1
- rd_data_valid / rd_data_ready  out/in  1  read data handshake
- rd_data  out  DATA_WIDTH  read beat
- rd_data_last  out  1  final beat of burst
- mem_write_en, mem_read_en  out  1  memory port enables
- mem_write_address, mem_read_address  out  ADDR_WIDTH  memory addresses
- mem_data_in  out  DATA_WIDTH  memory write data
- mem_data_out  in  DATA_WIDTH  memory read data; valid the cycle after the edge that sampled mem_read_en

## Operation

- Write FSM states:
  - W_IDLE: wr_cmd_ready=1; a handshake latches addr and remaining=len, then goes to W_DATA.
  - W_DATA: wr_data_ready=1; each handshake drives the memory write and increments addr; the handshake with remaining==0 goes to W_RESP.
  - W_RESP: wr_resp_valid=1 until wr_resp_ready, then goes to W_IDLE.
- Memory write driving is combinational: mem_write_en = wr_data_valid & wr_data_ready; mem_write_address = addr reg; mem_data_in = wr_data.
- Read FSM states:
  - R_IDLE: rd_cmd_ready=1; a handshake latches addr/len and goes to R_ISSUE.
  - R_ISSUE: mem_read_en=1 when credit is available; each issue increments addr; the last issue returns to R_IDLE.
- Credit: (fifo_count + inflight − pop_this_cycle) < 2.
- inflight: 1-bit register set by an issue; the next edge pushes {mem_data_out, last_tag} into the FIFO.
- 2-entry FIFO outputs: rd_data_valid = !empty; rd_data / rd_data_last come from the head entry; pop = rd_data_valid & rd_data_ready.
- Overflow is impossible by credit construction.
- Address arithmetic is modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH−1 wraps to 0 mid-burst.
- A new read command may be accepted while beats of the previous burst are still in FIFO/inflight; last tags keep bursts separated.
- Reset (async, any time): FSMs go to idle; FIFO is emptied; inflight is cleared; in-progress bursts are abandoned with no response.
- Reset values: wr_cmd_ready=0, rd_cmd_ready=0 while rst_n low; all other outputs 0.
- Ready outputs rise in the first cycle after rst_n deasserts.

## Timing

- Write: cmd handshake at edge 0; wr_data_ready=1 from cycle 1.
  - Data beat N accepted at edge N+1; memory is written at that same edge.
  - wr_resp_valid is asserted in the cycle after the last beat edge.
  - Throughput is 1 beat/cycle.
- Read: cmd handshake at edge 0; mem_read_en in cycle 1; data pushed at edge 2; rd_data_valid in cycle 3 (3-cycle latency).
  - Throughput is 1 beat/cycle with rd_data_ready held high.
  - With ready low, at most 2 beats are buffered and issue stalls.
- Simultaneous write and read of the same address, same cycle: read returns old data (memory read-before-write).

## Configuration

- MEM_RAW_ORDER_EN defined:
  - rd_cmd_ready is additionally gated by (write FSM == W_IDLE) & !(wr_cmd_valid & wr_cmd_ready).
  - Reads therefore observe all previously started writes; a pending write command wins a same-cycle tie.
- Not defined: read and write channels are fully independent.

## Test plan

- Write addr 0x010, len 3, data A0..A3, resp ready → 4 mem writes to 0x010..0x013; wr_resp_valid one cycle after last beat.
- Read addr 0x010, len 3, ready high → rd_data A0,A1,A2,A3 on consecutive cycles starting 3 cycles after cmd; last on A3.
- Read len 7 with rd_data_ready toggled 1-0 every cycle → 8 beats, in order, none lost or duplicated; mem_read_en never drives more than 2 outstanding beats.
- Write addr 0x3FE, len 3 (ADDR_WIDTH 10) → addresses 0x3FE,0x3FF,0x000,0x001.
- Assert rst_n low mid read burst, then issue read addr 0x011 len 0 → all outputs 0 during reset; single beat A1 with last=1.
- Overlapping write and read commands in the same cycle: with MEM_RAW_ORDER_EN, rd_cmd_ready stays 0 until the write response completes, and reads return the new data. Without the macro, both commands are accepted immediately.
